// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   ADDR_W      : byte-address bits decoded by DataMemory (word index is Address[ADDR_W-1:2])
//   F3_*        : RV32I load/store funct3 width encodings
//   lsu_state_e : sub-word store sequencer states
package lsu_pkg;

  localparam int ADDR_W = 12;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Bus bundle between the EX/MEM pipeline, the load/store unit and DataMemory.
//   Pipeline side : MemRead, MemWrite, funct3, Address, StoreData -> LSU
//                   LoadData, Stall, MisalignFault                  <- LSU
//   Memory side   : mem_MemWrite, mem_Address, mem_WriteData       <- LSU
//                   mem_ReadData (asynchronous read)                -> LSU
// slave  : the load/store unit itself
// master : the environment (pipeline plus DataMemory)
interface lsu_if;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] Address;
  logic [31:0] StoreData;
  logic [31:0] LoadData;
  logic        Stall;
  logic        MisalignFault;
  logic        mem_MemWrite;
  logic [31:0] mem_Address;
  logic [31:0] mem_WriteData;
  logic [31:0] mem_ReadData;

  modport slave (
    input  MemRead, MemWrite, funct3, Address, StoreData, mem_ReadData,
    output LoadData, Stall, MisalignFault, mem_MemWrite, mem_Address, mem_WriteData
  );

  modport master (
    output MemRead, MemWrite, funct3, Address, StoreData, mem_ReadData,
    input  LoadData, Stall, MisalignFault, mem_MemWrite, mem_Address, mem_WriteData
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for the load/store unit (little-endian lanes).
//   rdata       in  32 : word read from DataMemory
//   byte_off    in   2 : Address[1:0]
//   funct3      in   3 : access width / signedness
//   store_lo    in  16 : low half of StoreData (byte in [7:0])
//   load_data   out 32 : extracted and extended load value (0 for illegal funct3)
//   merged_data out 32 : rdata with the addressed byte/half replaced by store_lo
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  input  logic [15:0] store_lo,
  output logic [31:0] load_data,
  output logic [31:0] merged_data
);

  logic [7:0]  lane_byte_s;
  logic [15:0] lane_half_s;

  // Load path: pick the addressed lane, then sign- or zero-extend it.
  always_comb begin
    lane_byte_s = 8'h00;
    case (byte_off)
      2'b00:   lane_byte_s = rdata[7:0];
      2'b01:   lane_byte_s = rdata[15:8];
      2'b10:   lane_byte_s = rdata[23:16];
      2'b11:   lane_byte_s = rdata[31:24];
      default: lane_byte_s = 8'h00;
    endcase
    lane_half_s = byte_off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    load_data = {{24{lane_byte_s[7]}}, lane_byte_s};
      F3_BU:   load_data = {24'h000000, lane_byte_s};
      F3_H:    load_data = {{16{lane_half_s[15]}}, lane_half_s};
      F3_HU:   load_data = {16'h0000, lane_half_s};
      F3_W:    load_data = rdata;
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Store path: overwrite only the target lane; everything else keeps the read word.
  always_comb begin
    merged_data = rdata;
    if (funct3 == F3_H) begin
      if (byte_off[1]) begin
        merged_data[31:16] = store_lo;
      end else begin
        merged_data[15:0] = store_lo;
      end
    end else begin
      case (byte_off)
        2'b00:   merged_data[7:0]   = store_lo[7:0];
        2'b01:   merged_data[15:8]  = store_lo[7:0];
        2'b10:   merged_data[23:16] = store_lo[7:0];
        2'b11:   merged_data[31:24] = store_lo[7:0];
        default: merged_data        = rdata;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage front end for a word-wide DataMemory: RV32I B/H/W loads and stores.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : lsu_if.slave -- pipeline request/response and DataMemory port
// Loads and SW complete in the request cycle. SB/SH take two cycles: the first
// stalls upstream and captures the merged word plus address, the second (MERGE)
// writes it from those saved copies.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  lsu_if.slave  bus
);

  lsu_state_e  state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] addr_q,  addr_d;

  logic        req_s;
  logic        fault_s;
  logic        sub_store_s;
  logic        word_store_s;
  logic        load_s;
  logic [31:0] ext_load_s;
  logic [31:0] merged_s;

  lsu_lane_align u_align (
    .rdata       (bus.mem_ReadData),
    .byte_off    (bus.Address[1:0]),
    .funct3      (bus.funct3),
    .store_lo    (bus.StoreData[15:0]),
    .load_data   (ext_load_s),
    .merged_data (merged_s)
  );

  // Request classification; faults only exist for requests accepted in IDLE.
  // A MemRead+MemWrite request is a store, so unsigned widths fault on it.
  always_comb begin
    req_s   = bus.MemRead | bus.MemWrite;
    fault_s = 1'b0;
    if ((state_q == IDLE) && req_s) begin
      case (bus.funct3)
        F3_B:    fault_s = 1'b0;
        F3_H:    fault_s = bus.Address[0];
        F3_W:    fault_s = |bus.Address[1:0];
        F3_BU:   fault_s = bus.MemWrite;
        F3_HU:   fault_s = bus.MemWrite | bus.Address[0];
        default: fault_s = 1'b1;
      endcase
    end else begin
      fault_s = 1'b0;
    end
    sub_store_s  = (state_q == IDLE) && bus.MemWrite && !fault_s &&
                   ((bus.funct3 == F3_B) || (bus.funct3 == F3_H));
    word_store_s = (state_q == IDLE) && bus.MemWrite && !fault_s && (bus.funct3 == F3_W);
    load_s       = (state_q == IDLE) && bus.MemRead && !bus.MemWrite && !fault_s;
  end

  // Next-state logic: capture merged word and address on a sub-word store.
  always_comb begin
    state_d = state_q;
    merge_d = merge_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (sub_store_s) begin
          state_d = MERGE;
          merge_d = merged_s;
          addr_d  = bus.Address;
        end else begin
          state_d = IDLE;
        end
      end
      MERGE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      merge_q <= 32'h0000_0000;
      addr_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      addr_q  <= addr_d;
    end
  end

  // Output steering. The MERGE write is gated by rst so a reset arriving in
  // MERGE drops the pending write instead of committing it on the same edge.
  always_comb begin
    bus.Stall         = sub_store_s & ~rst;
    bus.MisalignFault = fault_s & ~rst;
    bus.LoadData      = load_s ? ext_load_s : 32'h0000_0000;
    if (state_q == MERGE) begin
      bus.mem_MemWrite  = ~rst;
      bus.mem_Address   = addr_q;
      bus.mem_WriteData = merge_q;
    end else begin
      bus.mem_MemWrite  = word_store_s & ~rst;
      bus.mem_Address   = bus.Address;
      bus.mem_WriteData = bus.StoreData;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural DataMemory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk;
  logic rst;
  logic mem_clr;

  lsu_if bus ();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMemory model: async read, sync word write, index Address[11:2].
  logic [31:0] mem [0:(1 << (ADDR_W - 2)) - 1];
  assign bus.mem_ReadData = mem[bus.mem_Address[ADDR_W-1:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << (ADDR_W - 2)); i++) mem[i] <= 32'h0000_0000;
    end else if (bus.mem_MemWrite) begin
      mem[bus.mem_Address[ADDR_W-1:2]] <= bus.mem_WriteData;
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] exp_load;
    logic        exp_fault;
    logic        exp_we;
  } vec_t;

  vec_t vecs [16];
  vec_t sb_q [$];
  vec_t exp_v;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drv(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] sd);
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.funct3    = f3;
    bus.Address   = addr;
    bus.StoreData = sd;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic nextc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // mem[0x10] = 0x8899AABB: bytes 0x10=BB 0x11=AA 0x12=99 0x13=88
    vecs[0]  = '{1'b1, 1'b0, F3_B,   32'h11, 32'h0,   32'hFFFF_FFAA, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, F3_BU,  32'h11, 32'h0,   32'h0000_00AA, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, F3_H,   32'h12, 32'h0,   32'hFFFF_8899, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, F3_HU,  32'h12, 32'h0,   32'h0000_8899, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, F3_W,   32'h10, 32'h0,   32'h8899_AABB, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, F3_B,   32'h10, 32'h0,   32'hFFFF_FFBB, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, F3_B,   32'h12, 32'h0,   32'hFFFF_FF99, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, F3_H,   32'h10, 32'h0,   32'hFFFF_AABB, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, F3_H,   32'h11, 32'h0,   32'h0,         1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, F3_W,   32'h12, 32'h0,   32'h0,         1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h10, 32'h0,   32'h0,         1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, F3_B,   32'h13, 32'h0,   32'hFFFF_FF88, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, F3_BU,  32'h13, 32'h0,   32'h0000_0088, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, F3_BU,  32'h10, 32'h77,  32'h0,         1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, F3_H,   32'h21, 32'hBEEF,32'h0,         1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 3'b110, 32'h10, 32'h0,   32'h0,         1'b1, 1'b0};

    // Reset and clear memory
    rst = 1'b1;
    mem_clr = 1'b1;
    idle();
    nextc();
    nextc();
    rst = 1'b0;
    mem_clr = 1'b0;
    @(negedge clk);
    chk("reset_stall", {31'h0, bus.Stall}, 32'h0);
    chk("reset_we", {31'h0, bus.mem_MemWrite}, 32'h0);
    chk("reset_fault", {31'h0, bus.MisalignFault}, 32'h0);
    nextc();

    // Preload through the DUT with word stores
    drv(1'b0, 1'b1, F3_W, 32'h10, 32'h8899_AABB);
    @(negedge clk);
    chk("sw10_stall", {31'h0, bus.Stall}, 32'h0);
    chk("sw10_we", {31'h0, bus.mem_MemWrite}, 32'h1);
    chk("sw10_wdata", bus.mem_WriteData, 32'h8899_AABB);
    nextc();
    drv(1'b0, 1'b1, F3_W, 32'h20, 32'h1234_5678);
    @(negedge clk);
    chk("sw20_stall", {31'h0, bus.Stall}, 32'h0);
    chk("sw20_we", {31'h0, bus.mem_MemWrite}, 32'h1);
    nextc();
    drv(1'b0, 1'b1, F3_W, 32'h30, 32'h0);
    nextc();
    idle();
    chk("mem10_pre", mem[4], 32'h8899_AABB);
    chk("mem20_pre", mem[8], 32'h1234_5678);

    // Table-driven single-cycle accesses through a scoreboard queue
    for (int i = 0; i < 16; i++) begin
      drv(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].sd);
      sb_q.push_back(vecs[i]);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      chk($sformatf("vec%0d_load", i), bus.LoadData, exp_v.exp_load);
      chk($sformatf("vec%0d_fault", i), {31'h0, bus.MisalignFault}, {31'h0, exp_v.exp_fault});
      chk($sformatf("vec%0d_we", i), {31'h0, bus.mem_MemWrite}, {31'h0, exp_v.exp_we});
      chk($sformatf("vec%0d_stall", i), {31'h0, bus.Stall}, 32'h0);
      nextc();
    end
    idle();
    chk("mem10_after_faults", mem[4], 32'h8899_AABB);
    chk("mem20_after_sh_fault", mem[8], 32'h1234_5678);

    // SB 0x5C @0x13: stall one cycle, then merged write
    drv(1'b0, 1'b1, F3_B, 32'h13, 32'h0000_005C);
    @(negedge clk);
    chk("sb13_c1_stall", {31'h0, bus.Stall}, 32'h1);
    chk("sb13_c1_we", {31'h0, bus.mem_MemWrite}, 32'h0);
    nextc();
    @(negedge clk);
    chk("sb13_c2_stall", {31'h0, bus.Stall}, 32'h0);
    chk("sb13_c2_we", {31'h0, bus.mem_MemWrite}, 32'h1);
    chk("sb13_c2_wdata", bus.mem_WriteData, 32'h5C99_AABB);
    nextc();
    drv(1'b1, 1'b0, F3_W, 32'h10, 32'h0);
    @(negedge clk);
    chk("lw10_after_sb", bus.LoadData, 32'h5C99_AABB);
    nextc();

    // Back-to-back SB to the same word
    drv(1'b0, 1'b1, F3_B, 32'h30, 32'h0000_0011);
    @(negedge clk);
    chk("b2b_c1_stall", {31'h0, bus.Stall}, 32'h1);
    nextc();
    @(negedge clk);
    chk("b2b_c2_we", {31'h0, bus.mem_MemWrite}, 32'h1);
    nextc();
    drv(1'b0, 1'b1, F3_B, 32'h31, 32'h0000_0022);
    @(negedge clk);
    chk("b2b_c3_stall", {31'h0, bus.Stall}, 32'h1);
    chk("b2b_c3_we", {31'h0, bus.mem_MemWrite}, 32'h0);
    nextc();
    @(negedge clk);
    chk("b2b_c4_we", {31'h0, bus.mem_MemWrite}, 32'h1);
    chk("b2b_c4_wdata", bus.mem_WriteData, 32'h0000_2211);
    nextc();
    idle();
    chk("b2b_mem30", mem[12], 32'h0000_2211);

    // SH in flight, reset during MERGE drops the write
    drv(1'b0, 1'b1, F3_H, 32'h22, 32'h0000_BEEF);
    @(negedge clk);
    chk("shrst_c1_stall", {31'h0, bus.Stall}, 32'h1);
    nextc();
    rst = 1'b1;
    idle();
    @(negedge clk);
    chk("shrst_merge_we", {31'h0, bus.mem_MemWrite}, 32'h0);
    nextc();
    rst = 1'b0;
    @(negedge clk);
    chk("shrst_after_stall", {31'h0, bus.Stall}, 32'h0);
    chk("shrst_after_we", {31'h0, bus.mem_MemWrite}, 32'h0);
    chk("shrst_mem20", mem[8], 32'h1234_5678);
    nextc();
    drv(1'b1, 1'b0, F3_W, 32'h20, 32'h0);
    @(negedge clk);
    chk("lw20_final", bus.LoadData, 32'h1234_5678);
    nextc();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
